alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Sequential command front-end for the 4-bit combinational ALU. Accepts operation requests over a valid/ready handshake and registers the operands and select onto the ALU inputs. It holds them for a programmable settle time, then captures `ALU_Out`/`CarryOut` into a result register offered downstream with valid/ready. Sits between the register-file/sequencer logic and the ALU instance. Also provides an accumulator mode for chained operations.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles operands are held on the ALU before capture; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both high at a rising edge.
- `cmd_sel` in 4: ALU operation code.
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_acc` in 1: 1 = use accumulator as operand A and ignore `cmd_a`.
- `ALU_A` out 4: registered operand A to the ALU.
- `ALU_B` out 4: registered operand B to the ALU.
- `ALU_Sel` out 4: registered select to the ALU.
- `ALU_Out` in 4: ALU result, combinational from `ALU_A`/`ALU_B`/`ALU_Sel`.
- `CarryOut` in 1: ALU carry flag.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts the result.
- `res_data` out 4: captured `ALU_Out`.
- `res_carry` out 1: captured `CarryOut`.
- `res_sel` out 4: opcode tag of the captured result.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out 8: completed-operation counter; wraps 255 → 0.

## Operation
- Opcode encoding: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LSL, 5 LSR, 6 ROL, 7 ROR, 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR, 14 GT, 15 EQ. The driver passes `cmd_sel` through unchanged and does not interpret it.
- FSM states: IDLE, SETTLE, DONE.
  - IDLE: `cmd_ready`=1. On accept: load `ALU_A` (from `cmd_a`, or from the accumulator if `cmd_acc`), `ALU_B`, `ALU_Sel`; load the settle counter with `SETTLE_CYCLES-1`; go to SETTLE.
  - SETTLE: decrement the counter each cycle. At the edge where the counter is 0: capture `res_data`←`ALU_Out`, `res_carry`←`CarryOut`, `res_sel`←`ALU_Sel`, accumulator←`ALU_Out`; increment `op_count`; go to DONE.
  - DONE: `res_valid`=1, and the result registers are held stable. On `res_valid&&res_ready`:
    - if `cmd_valid` is also high: accept the new command in the same edge and go to SETTLE (back-to-back);
    - otherwise go to IDLE.
- `cmd_ready` = (state==IDLE) || (state==DONE && res_ready). It is low in SETTLE.
- `ALU_A`/`ALU_B`/`ALU_Sel` change only on command accept. They hold their values in DONE and IDLE.
- Accumulator: 4-bit, updated only at capture. `cmd_acc` in a back-to-back accept uses the result captured in the previous capture, which is the one currently in `res_data`.
- Arithmetic width: all 4-bit, no extension. The carry is whatever the ALU reports.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `res_valid`=0; `busy`=0; `ALU_A`/`ALU_B`/`ALU_Sel`/`res_data`/`res_sel`=0; `res_carry`=0; accumulator=0; `op_count`=0.
- Latency: accept at edge N → `res_valid` high after edge N+SETTLE_CYCLES. SETTLE_CYCLES=1 gives 1 cycle.
- Throughput:
  - with `res_ready` held high and back-to-back commands: one result per SETTLE_CYCLES+1 cycles;
  - without overlap in DONE: one result per SETTLE_CYCLES+2 cycles.
- Backpressure: `res_valid` stays high and `res_*` stay stable until `res_ready`. No result is ever dropped or overwritten.
- Reset mid-operation (SETTLE or DONE): the pending result is discarded, all registers return to their reset values, and no `op_count` increment occurs.
- `rst` takes priority over every handshake in the same cycle.

## Structure
- Shared package `alu_pkg`: 4-bit opcode constants (`OP_ADD`..`OP_EQ`, values above), the FSM state typedef, and the data width constant 4.
- One natural sub-module, `alu_settle_timer`: a loadable 4-bit down-counter with a `zero` flag, reusable by other multi-cycle ALU front-ends.
- The ALU itself is instantiated alongside this block at integration, not inside it.

## Test plan
- Reset, then ADD with A=9, B=8, SETTLE_CYCLES=1 → `ALU_Sel`=0; `res_data`=1, `res_carry`=1 one cycle after accept; `op_count`=1.
- MUL with A=3, B=5, then accumulator command XOR with B=0xF, `cmd_acc`=1 → first result 15, then `ALU_A`=15 and result 0; accumulator=0.
- Hold `res_ready`=0 for 5 cycles after a result → `res_valid` stays 1, `res_data` is unchanged, and `cmd_ready`=0 throughout.
- Back-to-back: `cmd_valid` and `res_ready` both high in DONE → new command accepted on the same edge as result retirement, with no IDLE cycle between.
- SETTLE_CYCLES=4, and assert `rst` during the third SETTLE cycle → all outputs at reset values next cycle, no `res_valid` pulse, `op_count` unchanged at 0.
- Issue 256 operations → `op_count` wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU front-end blocks: data width,
// opcode constants and the command-driver FSM state type.
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_LSL  = 4'd4;
    localparam logic [3:0] OP_LSR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag; counts the cycles operands
// are held on the ALU before its outputs are trusted.
module alu_settle_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Load wins over decrement; the counter saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequential command front-end for the combinational 4-bit ALU: registers
// operands onto the ALU, waits SETTLE_CYCLES, captures the result for downstream.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_sel,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    input  logic        cmd_acc,
    output logic [3:0]  ALU_A,
    output logic [3:0]  ALU_B,
    output logic [3:0]  ALU_Sel,
    input  logic [3:0]  ALU_Out,
    input  logic        CarryOut,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_data,
    output logic        res_carry,
    output logic [3:0]  res_sel,
    output logic        busy,
    output logic [7:0]  op_count,
    output logic [1:0]  dbg_state
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a result retires on a rising edge where res_valid && res_ready.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t state_q, state_d;

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_carry_q, res_carry_d;
    logic [3:0]        res_sel_q, res_sel_d;
    logic [7:0]        op_count_q, op_count_d;

    logic accept;
    logic capture;
    logic timer_zero;

    alu_settle_timer u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (accept),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (state_q == ST_SETTLE),
        .zero_o     (timer_zero)
    );

    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign capture   = (state_q == ST_SETTLE) && timer_zero;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)     state_d = ST_SETTLE;
            ST_SETTLE: if (timer_zero) state_d = ST_DONE;
            ST_DONE:   if (res_ready)  state_d = cmd_valid ? ST_SETTLE : ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // The accumulator always equals the most recent capture, so a back-to-back
    // accumulate command chains on the result being retired in the same edge.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_sel_d   = res_sel_q;
        op_count_d  = op_count_q;
        if (accept) begin
            alu_a_d   = cmd_acc ? acc_q : cmd_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_sel;
        end
        if (capture) begin
            res_data_d  = ALU_Out;
            res_carry_d = CarryOut;
            res_sel_d   = alu_sel_q;
            acc_d       = ALU_Out;
            op_count_d  = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_sel_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_sel_q   <= res_sel_d;
            op_count_q  <= op_count_d;
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_Sel   = alu_sel_q;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_sel   = res_sel_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_count  = op_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two instances (settle 1 and 4) driven by directed and
// random traffic, checked every cycle against a timestamp-based transaction model.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cmd_valid [2];
    logic       cmd_acc   [2];
    logic       res_ready [2];
    logic [3:0] cmd_sel   [2];
    logic [3:0] cmd_a     [2];
    logic [3:0] cmd_b     [2];
    logic       cmd_ready [2];
    logic       res_valid [2];
    logic       res_carry [2];
    logic       busy      [2];
    logic       carry_in  [2];
    logic [3:0] alu_a     [2];
    logic [3:0] alu_b     [2];
    logic [3:0] alu_sel   [2];
    logic [3:0] alu_out   [2];
    logic [3:0] res_data  [2];
    logic [3:0] res_sel   [2];
    logic [7:0] op_count  [2];
    logic [1:0] dbg_state [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in 4-bit ALU: returns {carry, result}
    function automatic logic [4:0] alu_f(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [4:0] r;
        p = 8'(a) * 8'(b);
        case (sel)
            4'd0:  r = 5'(a) + 5'(b);
            4'd1:  r = 5'(a) - 5'(b);
            4'd2:  r = {|p[7:4], p[3:0]};
            4'd3:  r = (b == 4'd0) ? 5'd0 : {1'b0, a / b};
            4'd4:  r = {a[3], a[2:0], 1'b0};
            4'd5:  r = {a[0], 1'b0, a[3:1]};
            4'd6:  r = {1'b0, a[2:0], a[3]};
            4'd7:  r = {1'b0, a[0], a[3:1]};
            4'd8:  r = {1'b0, a & b};
            4'd9:  r = {1'b0, a | b};
            4'd10: r = {1'b0, a ^ b};
            4'd11: r = {1'b0, ~(a | b)};
            4'd12: r = {1'b0, ~(a & b)};
            4'd13: r = {1'b0, ~(a ^ b)};
            4'd14: r = {4'd0, a > b};
            default: r = {4'd0, a == b};
        endcase
        return r;
    endfunction

    function automatic int s_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    alu_cmd_driver #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_sel(cmd_sel[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_acc(cmd_acc[0]),
        .ALU_A(alu_a[0]), .ALU_B(alu_b[0]), .ALU_Sel(alu_sel[0]),
        .ALU_Out(alu_out[0]), .CarryOut(carry_in[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
        .res_carry(res_carry[0]), .res_sel(res_sel[0]), .busy(busy[0]),
        .op_count(op_count[0]), .dbg_state(dbg_state[0])
    );

    alu_cmd_driver #(.SETTLE_CYCLES(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_sel(cmd_sel[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_acc(cmd_acc[1]),
        .ALU_A(alu_a[1]), .ALU_B(alu_b[1]), .ALU_Sel(alu_sel[1]),
        .ALU_Out(alu_out[1]), .CarryOut(carry_in[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
        .res_carry(res_carry[1]), .res_sel(res_sel[1]), .busy(busy[1]),
        .op_count(op_count[1]), .dbg_state(dbg_state[1])
    );

    assign {carry_in[0], alu_out[0]} = alu_f(alu_sel[0], alu_a[0], alu_b[0]);
    assign {carry_in[1], alu_out[1]} = alu_f(alu_sel[1], alu_a[1], alu_b[1]);

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s[%0d] got=%0h expected=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: one transaction in flight at most. An accept at edge e makes
    // the result visible after edge e+S; it stays visible until retired.
    int         edge_n = 0;
    bit         live   = 0;
    bit         m_busy [2];
    int         m_rdy  [2];
    int         m_caps [2];
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    logic [3:0] m_sel  [2];
    logic [3:0] m_acc  [2];
    logic [7:0] m_cnt  [2];
    logic [8:0] m_last [2];   // {sel, carry, data} of the latest capture
    logic [8:0] exp_q0 [$];
    logic [8:0] exp_q1 [$];

    function automatic logic [8:0] q_front(input int k);
        if (k == 0) return (exp_q0.size() > 0) ? exp_q0[0] : 9'h0;
        return (exp_q1.size() > 0) ? exp_q1[0] : 9'h0;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            live = 1;
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_rdy[k] = 0; m_caps[k] = 0;
                m_a[k] = '0; m_b[k] = '0; m_sel[k] = '0; m_acc[k] = '0;
                m_cnt[k] = '0; m_last[k] = '0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else if (live) begin
            for (int k = 0; k < 2; k++) begin
                bit         vnow, rnow;
                logic [3:0] a;
                logic [8:0] e;
                vnow = m_busy[k] && ((edge_n - 1) >= m_rdy[k]);
                rnow = !m_busy[k] || (vnow && res_ready[k]);
                if (m_busy[k] && edge_n == m_rdy[k]) begin
                    m_last[k] = q_front(k);
                    m_acc[k]  = m_last[k][3:0];
                    m_cnt[k]  = m_cnt[k] + 8'd1;
                    m_caps[k]++;
                end
                if (vnow && res_ready[k]) begin
                    m_busy[k] = 0;
                    if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                end
                if (cmd_valid[k] && rnow) begin
                    a = cmd_acc[k] ? m_acc[k] : cmd_a[k];
                    m_a[k] = a; m_b[k] = cmd_b[k]; m_sel[k] = cmd_sel[k];
                    e = {cmd_sel[k], alu_f(cmd_sel[k], a, cmd_b[k])};
                    if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
                    m_busy[k] = 1;
                    m_rdy[k]  = edge_n + s_of(k);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 2; k++) begin
                bit         vexp;
                logic [8:0] r;
                vexp = m_busy[k] && (edge_n >= m_rdy[k]);
                r    = vexp ? q_front(k) : m_last[k];
                chk("res_valid", k, 32'(res_valid[k]), 32'(vexp));
                chk("cmd_ready", k, 32'(cmd_ready[k]), 32'(!m_busy[k] || (vexp && res_ready[k])));
                chk("busy",      k, 32'(busy[k]),      32'(m_busy[k]));
                chk("ALU_A",     k, 32'(alu_a[k]),     32'(m_a[k]));
                chk("ALU_B",     k, 32'(alu_b[k]),     32'(m_b[k]));
                chk("ALU_Sel",   k, 32'(alu_sel[k]),   32'(m_sel[k]));
                chk("op_count",  k, 32'(op_count[k]),  32'(m_cnt[k]));
                chk("res_data",  k, 32'(res_data[k]),  32'(r[3:0]));
                chk("res_carry", k, 32'(res_carry[k]), 32'(r[4]));
                chk("res_sel",   k, 32'(res_sel[k]),   32'(r[8:5]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 0; cmd_acc[k] = 0; res_ready[k] = 0;
            cmd_sel[k] = '0; cmd_a[k] = '0; cmd_b[k] = '0;
        end
    endtask

    task automatic drive_cmd(input int k, input logic [3:0] sel, input logic [3:0] a,
                             input logic [3:0] b, input logic acc);
        cmd_valid[k] = 1; cmd_sel[k] = sel; cmd_a[k] = a; cmd_b[k] = b; cmd_acc[k] = acc;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic randomize_inputs(input int k);
        cmd_valid[k] = ($urandom_range(0, 3) != 0);
        res_ready[k] = ($urandom_range(0, 2) != 0);
        cmd_acc[k]   = ($urandom_range(0, 3) == 0);
        cmd_sel[k]   = 4'($urandom_range(0, 15));
        cmd_a[k]     = 4'($urandom_range(0, 15));
        cmd_b[k]     = 4'($urandom_range(0, 15));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst = 1;
        idle_all();
        do_reset();
        step();

        // reset values
        chk("rst_res_valid", 0, 32'(res_valid[0]), 32'd0);
        chk("rst_cmd_ready", 0, 32'(cmd_ready[0]), 32'd1);
        chk("rst_busy",      0, 32'(busy[0]),      32'd0);
        chk("rst_op_count",  0, 32'(op_count[0]),  32'd0);
        chk("rst_ALU_A",     0, 32'(alu_a[0]),     32'd0);

        // ADD 9+8 -> 1 with carry, one cycle after accept
        drive_cmd(0, 4'd0, 4'd9, 4'd8, 1'b0);
        step();
        cmd_valid[0] = 0;
        chk("add_ALU_Sel", 0, 32'(alu_sel[0]), 32'd0);
        chk("add_ALU_A",   0, 32'(alu_a[0]),   32'd9);
        chk("add_valid0",  0, 32'(res_valid[0]), 32'd0);
        step();
        chk("add_valid",   0, 32'(res_valid[0]), 32'd1);
        chk("add_data",    0, 32'(res_data[0]),  32'd1);
        chk("add_carry",   0, 32'(res_carry[0]), 32'd1);
        chk("add_count",   0, 32'(op_count[0]),  32'd1);

        // backpressure: result held, no new command accepted
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid",     0, 32'(res_valid[0]), 32'd1);
            chk("bp_data",      0, 32'(res_data[0]),  32'd1);
            chk("bp_cmd_ready", 0, 32'(cmd_ready[0]), 32'd0);
        end
        res_ready[0] = 1;
        step();
        res_ready[0] = 0;
        chk("retire_busy", 0, 32'(busy[0]), 32'd0);

        // MUL 3*5 = 15, then back-to-back accumulate XOR 0xF -> 0
        drive_cmd(0, 4'd2, 4'd3, 4'd5, 1'b0);
        step();
        cmd_valid[0] = 0;
        step();
        chk("mul_data", 0, 32'(res_data[0]), 32'd15);
        res_ready[0] = 1;
        drive_cmd(0, 4'd10, 4'd6, 4'hF, 1'b1);
        #1;
        chk("b2b_cmd_ready", 0, 32'(cmd_ready[0]), 32'd1);
        step();
        cmd_valid[0] = 0;
        chk("acc_ALU_A", 0, 32'(alu_a[0]), 32'd15);
        chk("b2b_busy",  0, 32'(busy[0]),  32'd1);
        step();
        chk("acc_data",  0, 32'(res_data[0]), 32'd0);
        chk("acc_count", 0, 32'(op_count[0]), 32'd3);
        step();
        res_ready[0] = 0;

        // settle=4 instance: reset during the third settle cycle
        drive_cmd(1, 4'd0, 4'd1, 4'd2, 1'b0);
        step();
        cmd_valid[1] = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_valid",     1, 32'(res_valid[1]), 32'd0);
        chk("mid_rst_busy",      1, 32'(busy[1]),      32'd0);
        chk("mid_rst_op_count",  1, 32'(op_count[1]),  32'd0);
        chk("mid_rst_ALU_A",     1, 32'(alu_a[1]),     32'd0);
        chk("mid_rst_cmd_ready", 1, 32'(cmd_ready[1]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_rst_no_pulse", 1, 32'(res_valid[1]), 32'd0);
        end

        // 256 operations wrap op_count back to 0
        res_ready[0] = 1;
        guard = 0;
        while (m_caps[0] < 256 && guard < 3000) begin
            drive_cmd(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'b0);
            step();
            guard++;
        end
        chk("wrap_reached", 0, 32'(m_caps[0]), 32'd256);
        chk("wrap_op_count", 0, 32'(op_count[0]), 32'd0);
        idle_all();
        step();
        step();

        // random traffic on both instances, with occasional resets
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            randomize_inputs(0);
            randomize_inputs(1);
            step();
        end
        rst = 0;
        idle_all();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
